// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative shift-add multiplier for RV M-extension multiplies
// Optional feature macro: MUL_EARLY_TERM_EN (stop as soon as the remaining multiplier is zero)

module mul_seq #(
  parameter int XLEN = 64,
  parameter int BPC  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Flush,
  input  logic [2:0]        Funct3,
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   SrcB,
  output logic              Busy,
  output logic              Done,
  output logic [2*XLEN-1:0] Prod
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2*XLEN-1:0] r_mcand;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mplier;
  logic [CW-1:0]     r_count;
  logic              r_neg;
  logic              r_done;

  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN-1:0]   w_mplier_next;
  logic [2*XLEN-1:0] w_pp;
  logic              w_last;
  logic              w_zero_b;

  // Operands are reduced to magnitudes; the result sign is reapplied in FIX.
  // 1xx encodings fall through as unsigned because neither sign term matches.
  assign w_sign_a = SrcA[XLEN-1] & ((Funct3 == 3'b001) | (Funct3 == 3'b010));
  assign w_sign_b = SrcB[XLEN-1] & (Funct3 == 3'b001);
  assign w_abs_a  = w_sign_a ? (-SrcA) : SrcA;
  assign w_abs_b  = w_sign_b ? (-SrcB) : SrcB;
  assign w_mplier_next = r_mplier >> BPC;

`ifdef MUL_EARLY_TERM_EN
  assign w_zero_b = (w_abs_b == '0);
  assign w_last   = (w_mplier_next == '0) | (r_count == CW'(N - 1));
`else
  assign w_zero_b = 1'b0;
  assign w_last   = (r_count == CW'(N - 1));
`endif

  // Partial product for the BPC low multiplier bits: sum of shifted multiplicands.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < BPC; i++) begin
      if (r_mplier[i]) begin
        w_pp = w_pp + (r_mcand << i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a flush overrides everything, including a same-cycle start.
  always_comb begin
    w_next = r_state;
    if (Flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (Start) w_next = w_zero_b ? S_FIX : S_BUSY;
        S_BUSY:  if (w_last) w_next = S_FIX;
        S_FIX:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: operand load, shift-add iterations and final sign fix-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!Flush) begin
        case (r_state)
          S_IDLE: begin
            if (Start) begin
              r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
              r_mplier <= w_abs_b;
              r_acc    <= '0;
              r_neg    <= w_sign_a ^ w_sign_b;
              r_count  <= '0;
            end
          end
          S_BUSY: begin
            r_acc    <= r_acc + w_pp;
            r_mcand  <= r_mcand << BPC;
            r_mplier <= w_mplier_next;
            r_count  <= r_count + 1'b1;
          end
          S_FIX: begin
            r_prod <= r_neg ? (-r_acc) : r_acc;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign Busy = (r_state != S_IDLE);
  assign Done = r_done;
  assign Prod = r_prod;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed vector bench for mul_seq (XLEN=64, BPC=2)

module tb_mul_seq;

  localparam int XLEN = 64;
  localparam int BPC  = 2;

  logic              clk;
  logic              reset;
  logic              Start;
  logic              Flush;
  logic [2:0]        Funct3;
  logic [XLEN-1:0]   SrcA;
  logic [XLEN-1:0]   SrcB;
  logic              Busy;
  logic              Done;
  logic [2*XLEN-1:0] Prod;

  int n_checks;
  int n_fail;

  mul_seq #(.XLEN(XLEN), .BPC(BPC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Prod(Prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        f3;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [2*XLEN-1:0] p;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [2*XLEN-1:0] act, input logic [2*XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected number of edges from the Start sample to the Done edge.
  function automatic int exp_lat(input logic [2:0] f3, input logic [XLEN-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    logic [XLEN-1:0] mag;
    int bl;
    mag = (f3 == 3'b001 && b[XLEN-1]) ? -b : b;
    bl = 0;
    for (int i = 0; i < XLEN; i++) if (mag[i]) bl = i + 1;
    return (bl + BPC - 1) / BPC + 1;
`else
    return XLEN / BPC + 1;
`endif
  endfunction

  // Issue one op from a point away from the clock edge and wait for Done.
  task automatic run_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output int lat);
    Funct3 = f3; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("busy_after_start", 128'(Busy), 128'(1));
    chk("done_single_pulse", 128'(Done), 128'(0));
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (Done) begin
        lat = k;
        break;
      end
    end
    chk("busy_low_at_done", 128'(Busy), 128'(0));
  endtask

  initial begin
    int lat;
    logic saw_done;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'h1};
    vecs[1]  = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA};
    vecs[2]  = '{3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 128'h4000_0000_0000_0000_0000_0000_0000_0000};
    vecs[3]  = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    vecs[4]  = '{3'b000, 64'h5, 64'h3, 128'd15};
    vecs[5]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 128'h1_FFFF_FFFF_FFFF_FFFE};
    vecs[6]  = '{3'b010, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 128'h2_FFFF_FFFF_FFFF_FFFD};
    vecs[7]  = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFD, 64'h7, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB};
    vecs[8]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 128'h1_FFFF_FFFF_FFFF_FFFE};
    vecs[9]  = '{3'b001, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 128'hC000_0000_0000_0000_8000_0000_0000_0000};
    vecs[10] = '{3'b000, 64'h5, 64'h0, 128'h0};

    reset = 1'b1; Start = 1'b0; Flush = 1'b0; Funct3 = 3'b000; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(Busy), 128'(0));
    chk("reset_done", 128'(Done), 128'(0));
    chk("reset_prod", Prod, 128'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_prod", i), Prod, vecs[i].p);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(exp_lat(vecs[i].f3, vecs[i].b)));
    end

    // Flush in flight: no Done, Prod keeps the previous result.
    Funct3 = 3'b011; SrcA = 64'h2; SrcB = 64'hFFFF_FFFF_FFFF_FFFF; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin @(posedge clk); #1; saw_done |= Done; end
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    chk("flush_busy", 128'(Busy), 128'(0));
    chk("flush_done", 128'(Done), 128'(0));
    chk("flush_prod_held", Prod, vecs[10].p);
    repeat (40) begin @(posedge clk); #1; saw_done |= Done; end
    chk("flush_no_done", 128'(saw_done), 128'(0));

    // Start pulsed mid-operation is ignored.
    Funct3 = 3'b011; SrcA = 64'h3; SrcB = 64'h8000_0000_0000_0001; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      if (k == 5) begin Start = 1'b1; SrcA = 64'd100; SrcB = 64'd100; end
      @(posedge clk); #1;
      Start = 1'b0;
      if (Done) begin lat = k; break; end
    end
    chk("ignored_start_prod", Prod, 128'h1_8000_0000_0000_0003);
    chk("ignored_start_latency", 128'(lat), 128'(XLEN / BPC + 1));
    @(posedge clk); #1;
    chk("ignored_start_no_second_op", 128'(Busy), 128'(0));

    // Back-to-back: second Start issued in the Done cycle.
    run_op(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    chk("b2b_first_prod", Prod, 128'h1);
    run_op(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    chk("b2b_second_prod", Prod, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    chk("b2b_second_latency", 128'(lat), 128'(XLEN / BPC + 1));

    // Asynchronous reset mid-operation clears everything immediately.
    Funct3 = 3'b000; SrcA = 64'h9; SrcB = 64'hFFFF_FFFF_FFFF_FFFF; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midreset_busy", 128'(Busy), 128'(0));
    chk("midreset_done", 128'(Done), 128'(0));
    chk("midreset_prod", Prod, 128'(0));
    @(negedge clk);
    reset = 1'b0;
    run_op(3'b000, 64'h5, 64'h3, lat);
    chk("post_reset_prod", Prod, 128'd15);
    chk("post_reset_latency", 128'(lat), 128'(exp_lat(3'b000, 64'h3)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
